uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous UART receiver, 8N1 format, recovering bytes from the serial `rx` pin using a 16× baud oversampling tick. It pairs with `uart_tx` and shares its baud tick generator and enable gating. It sits between the board RX pin and the byte-consuming logic, such as a command parser or FIFO. It adds input synchronisation, start-bit glitch rejection, framing-error detection and break (stuck-low) recovery.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: `rx_tick` pulses per bit period.
- Clocking and reset: reset `reset`, asynchronous, active-high; clock `clk`.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous active-high reset.
- `enable` input 1: when low, FSM, counters and outputs hold; the synchronizer keeps running.
- `rx` input 1: raw serial line, idle high, asynchronous to `clk`.
- `rx_tick` input 1: one-`clk` pulse at `OVERSAMPLE` × baud.
- `rx_data` output `DATA_BITS`: last correctly framed byte; holds until the next good frame.
- `rx_done` output 1: one-`clk` pulse when `rx_data` updates.
- `frame_error` output 1: one-`clk` pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1. All FSM decisions use the synchronized `rx_s`.
- Counters:
  - `tick_count` is 4 bits.
  - `bit_count` is `$clog2(DATA_BITS)` bits.
  - Shift register `shreg` is `DATA_BITS` wide.
  - All counters advance only on cycles with `enable && rx_tick`.
- States:
  - **IDLE**: when `rx_s == 0` → START, `tick_count = 0`. No tick is required to leave IDLE.
  - **START**: on each tick, if `tick_count == OVERSAMPLE/2-1` (7), sample `rx_s`.
    - If 0: → DATA, `tick_count = 0`, `bit_count = 0`.
    - If 1: glitch → IDLE, with no output pulse.
    - Otherwise increment `tick_count`.
  - **DATA**: on each tick, if `tick_count == 15`, set `shreg = {rx_s, shreg[DATA_BITS-1:1]}` and `tick_count = 0`.
    - If `bit_count == DATA_BITS-1` → STOP.
    - Otherwise increment `bit_count`.
    - Samples therefore fall at mid-bit.
  - **STOP**: on each tick, if `tick_count == 15`, sample `rx_s`.
    - If 1: `rx_data <= shreg`, pulse `rx_done`, → IDLE.
    - If 0: pulse `frame_error`, leave `rx_data` unchanged, → BREAK.
  - **BREAK**: wait until `rx_s == 1`, then → IDLE. This prevents a stuck-low line from re-triggering frames.
  - Any illegal encoding → IDLE.
- `rx_done` and `frame_error` are registered and mutually exclusive.
- Reset mid-frame: go to IDLE immediately. The partial byte is discarded, with no pulse.
- Deasserting `enable` mid-frame freezes the frame position. Reception resumes when `enable` returns high, with no realignment.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_done` = 0, `frame_error` = 0.
  - state = IDLE, counters = 0, synchronizer flops = 1.
- Falling edge on `rx` to START entry: 3 `clk` (2 sync flops plus the state register).
- Start detect to `rx_done`: 8 + 16·8 + 16 = 152 `rx_tick`s, plus 1 `clk`.
  - Stop is sampled at mid-stop-bit, so back-to-back frames at full baud are accepted.
- `rx_done`/`frame_error` assert in the `clk` cycle after the qualifying tick and last exactly 1 `clk`.
- There is no consumer backpressure. A consumer must capture `rx_data` before the next `rx_done`, which is at least 160 ticks away.
- A start glitch shorter than 8 ticks returns the FSM to IDLE within 8 ticks.

## Structure
- The shared include `uart_defs.vh` holds:
  - state localparams: IDLE, START, DATA, STOP, BREAK;
  - `OVERSAMPLE` and the default `DATA_BITS`;
  - the `uart_tx` encodings, which are moved there.
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with parameterised reset value, instantiated with reset value 1. It is reused for other asynchronous inputs.
- Registered state and counters are in one sequential block; next-state logic is in one combinational block.

## Test plan
- Bench setup: `rx_tick` every 4 `clk`, `enable = 1`.
- Good frame: drive 0x5A at 8N1 → `rx_data = 0x5A`, one `rx_done` pulse, `frame_error` stays 0.
- Back-to-back: send 0x00, 0xFF, 0xA5 with no idle gap → three `rx_done` pulses, data in order, no errors.
- Glitch: `rx` low for 5 ticks, then high → no pulse, FSM back in IDLE, next frame 0x3C received correctly.
- Framing error: send 0x81 with stop bit low, then `rx` high → `frame_error` pulses once, `rx_data` keeps its previous value, no `rx_done`.
- Break: hold `rx` low for 40 bit-times, then send 0x42 → exactly one `frame_error`, then `rx_done` with 0x42.
- Reset and enable:
  - Assert `reset` during bit 4 of 0x77 → outputs return to reset values, no pulse, and the following frame 0x11 is received.
  - Drop `enable` for 100 `clk` mid-frame with the line held stable → byte still correct.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: oversampling ratio, default frame width and the
// FSM state encodings for both the receiver and the paired transmitter.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  // Receiver FSM encodings (plain constants so legacy code can reuse them).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Transmitter FSM encodings, kept beside the receiver's so both stay in step.
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Width of a counter that must reach n-1 (never narrower than one bit).
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: line, tick and enable in; recovered byte and pulses out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic                 rx;
  logic                 rx_tick;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_error;

  // Driving side: supplies the line and timing, consumes bytes.
  modport master (
    output enable, rx, rx_tick,
    input  rx_data, rx_done, frame_error
  );

  // Receiver side.
  modport slave (
    input  enable, rx, rx_tick,
    output rx_data, rx_done, frame_error
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-stage resynchronisation into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so each flop takes the previous stage's old value.
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start-glitch rejection,
// framing-error detection and break (stuck-low) recovery.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int BW = count_width(DATA_BITS);
  localparam logic [3:0]    TICK_HALF = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 adv;
  logic [2:0]           state, state_d;
  logic [3:0]           tick_count, tick_d;
  logic [BW-1:0]        bit_count, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  assign adv = bus.enable && bus.rx_tick;

  // Next-state, counter and output decisions for the frame FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d = state;
    tick_d  = tick_count;
    bit_d   = bit_count;
    shreg_d = shreg;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enable && !rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (adv) begin
          if (tick_count == TICK_HALF) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_count + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (adv) begin
          if (tick_count == TICK_LAST) begin
            shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_count == BIT_LAST) state_d = ST_STOP;
            else                       bit_d   = bit_count + 1'b1;
          end else begin
            tick_d = tick_count + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (adv) begin
          if (tick_count == TICK_LAST) begin
            if (rx_s) begin
              data_d  = shreg;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tick_d = tick_count + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (bus.enable && rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      tick_count <= '0;
      bit_count  <= '0;
      shreg      <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_d;
      tick_count <= tick_d;
      bit_count  <= bit_d;
      shreg      <= shreg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_done     = done_q;
  assign bus.frame_error = err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor
// pops and compares on every rx_done / frame_error pulse.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk per tick

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tick_div = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One-clk rx_tick every 4 clk, changed on the falling edge.
  always @(negedge clk) begin
    tick_div   = (tick_div + 1) % 4;
    bus.rx_tick = (tick_div == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // Serial 8N1 frame, LSB first; freeze_bit >= 0 drops enable mid-bit.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int freeze_bit);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      if (i == freeze_bit) begin
        repeat (BIT_CLK/2) @(negedge clk);
        bus.enable = 1'b0;
        repeat (100) @(negedge clk);
        bus.enable = 1'b1;
        repeat (BIT_CLK/2) @(negedge clk);
      end else begin
        repeat (BIT_CLK) @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.rx_done === 1'b1 || bus.frame_error === 1'b1)) begin
      check("pulse_exclusive", 32'(bus.rx_done & bus.frame_error), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: rx_done=%0b frame_error=%0b rx_data=0x%0h, no event expected",
                 bus.rx_done, bus.frame_error, bus.rx_data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(bus.frame_error), 32'(e.is_err));
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus.rx     = 1'b1;
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_rx_done", 32'(bus.rx_done), 32'h0);
    check("reset_frame_error", 32'(bus.frame_error), 32'h0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    idle(2*BIT_CLK);

    // Single good frame
    push_exp(1'b0, 8'h5A);
    send_byte(8'h5A, 1'b1, -1);
    idle(BIT_CLK);

    // Back-to-back frames, no idle gap
    push_exp(1'b0, 8'h00);
    push_exp(1'b0, 8'hFF);
    push_exp(1'b0, 8'hA5);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'hFF, 1'b1, -1);
    send_byte(8'hA5, 1'b1, -1);
    idle(BIT_CLK);

    // Start glitch of 5 ticks, then a real frame
    bus.rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(BIT_CLK);
    check("glitch_state_idle", 32'(dut.state), 32'(ST_IDLE));
    push_exp(1'b0, 8'h3C);
    send_byte(8'h3C, 1'b1, -1);
    idle(BIT_CLK);

    // Framing error: rx_data keeps 0x3C
    push_exp(1'b1, 8'h3C);
    send_byte(8'h81, 1'b0, -1);
    idle(2*BIT_CLK);

    // Break: 40 bit-times low gives exactly one error, then recovery
    push_exp(1'b1, 8'h3C);
    bus.rx = 1'b0;
    repeat (40*BIT_CLK) @(negedge clk);
    idle(2*BIT_CLK);
    push_exp(1'b0, 8'h42);
    send_byte(8'h42, 1'b1, -1);
    idle(BIT_CLK);

    // Reset asserted during bit 4 of 0x77 and held to the end of the frame
    fork
      send_byte(8'h77, 1'b1, -1);
      begin
        repeat (BIT_CLK + 4*BIT_CLK + BIT_CLK/2) @(negedge clk);
        reset = 1'b1;
      end
    join
    check("midreset_rx_data", 32'(bus.rx_data), 32'h0);
    check("midreset_rx_done", 32'(bus.rx_done), 32'h0);
    check("midreset_frame_error", 32'(bus.frame_error), 32'h0);
    check("midreset_state", 32'(dut.state), 32'(ST_IDLE));
    idle(BIT_CLK);
    reset = 1'b0;
    idle(BIT_CLK);
    push_exp(1'b0, 8'h11);
    send_byte(8'h11, 1'b1, -1);
    idle(BIT_CLK);

    // Enable dropped for 100 clk in the middle of data bit 2
    push_exp(1'b0, 8'hC3);
    send_byte(8'hC3, 1'b1, 3);
    idle(BIT_CLK);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
